// File: rtl/crossing_ctrl.sv
// River-crossing puzzle sequencer: accepts a passenger request, animates the
// boat trip slot by slot, applies the eating rules and reports win/lose/err.
module crossing_ctrl #(
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned SLOTS    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic [1:0] sel,
  output logic [7:0] cat,
  output logic [7:0] dog,
  output logic [7:0] mouse,
  output logic       boat_side,
  output logic       busy,
  output logic       win,
  output logic       lose,
  output logic       err,
  output logic [7:0] move_cnt
);

  localparam int unsigned PW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int unsigned TW = $clog2(TICK_DIV);

  localparam logic [PW-1:0] LastSlot  = PW'(SLOTS - 1);
  localparam logic [PW-1:0] StepsLast = PW'(SLOTS - 2);
  localparam logic [TW-1:0] TickLast  = TW'(TICK_DIV - 1);

  typedef enum logic [2:0] {StIdle, StMove, StCheck, StWin, StLose} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [PW-1:0] step_q, step_d;
  logic [PW-1:0] cat_q, cat_d, dog_q, dog_d, mouse_q, mouse_d;
  logic [1:0]    pass_q, pass_d;
  logic          boat_q, boat_d;
  logic          busy_q, busy_d;
  logic          win_q, win_d;
  logic          lose_q, lose_d;
  logic          err_q, err_d;
  logic [7:0]    cnt_q, cnt_d;

  logic [PW-1:0] near_bank;
  logic [PW-1:0] away_bank;
  logic [PW-1:0] sel_pos;
  logic [PW-1:0] pass_pos;
  logic [PW-1:0] pass_next;

  function automatic logic [7:0] slot_pattern(input logic [PW-1:0] p);
    slot_pattern = 8'h03 << {p, 1'b0};
  endfunction

  // Slot lookups for the requested and the latched passenger
  always_comb begin
    near_bank = boat_q ? LastSlot : '0;
    // Unattended bank after the boat lands: opposite of the new boat side
    away_bank = (~boat_q) ? '0 : LastSlot;
    case (sel)
      2'd1:    sel_pos = cat_q;
      2'd2:    sel_pos = dog_q;
      default: sel_pos = mouse_q;
    endcase
    case (pass_q)
      2'd1:    pass_pos = cat_q;
      2'd2:    pass_pos = dog_q;
      default: pass_pos = mouse_q;
    endcase
    pass_next = boat_q ? (pass_pos - 1'b1) : (pass_pos + 1'b1);
  end

  // Next-state logic for the sequencer and all registered outputs
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    step_d  = step_q;
    cat_d   = cat_q;
    dog_d   = dog_q;
    mouse_d = mouse_q;
    pass_d  = pass_q;
    boat_d  = boat_q;
    busy_d  = busy_q;
    win_d   = win_q;
    lose_d  = lose_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (go) begin
          if (sel == 2'd0 || sel_pos == near_bank) begin
            pass_d  = sel;
            tick_d  = '0;
            step_d  = '0;
            busy_d  = 1'b1;
            state_d = StMove;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StMove: begin
        if (tick_q == TickLast) begin
          tick_d = '0;
          case (pass_q)
            2'd1:    cat_d   = pass_next;
            2'd2:    dog_d   = pass_next;
            2'd3:    mouse_d = pass_next;
            default: ;
          endcase
          if (step_q == StepsLast) begin
            state_d = StCheck;
          end else begin
            step_d = step_q + 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      StCheck: begin
        boat_d = ~boat_q;
        cnt_d  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        busy_d = 1'b0;
        if (cat_q == LastSlot && dog_q == LastSlot && mouse_q == LastSlot) begin
          win_d   = 1'b1;
          state_d = StWin;
        end else if (cat_q == away_bank && mouse_q == away_bank) begin
          lose_d  = 1'b1;
          state_d = StLose;
        end else if (dog_q == away_bank && cat_q == away_bank) begin
          lose_d  = 1'b1;
          state_d = StLose;
        end else begin
          state_d = StIdle;
        end
      end
      StWin, StLose: begin
        // Any go restarts the game from the initial layout
        if (go) begin
          cat_d   = '0;
          dog_d   = '0;
          mouse_d = '0;
          boat_d  = 1'b0;
          cnt_d   = '0;
          win_d   = 1'b0;
          lose_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      tick_q  <= '0;
      step_q  <= '0;
      cat_q   <= '0;
      dog_q   <= '0;
      mouse_q <= '0;
      pass_q  <= '0;
      boat_q  <= 1'b0;
      busy_q  <= 1'b0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      step_q  <= step_d;
      cat_q   <= cat_d;
      dog_q   <= dog_d;
      mouse_q <= mouse_d;
      pass_q  <= pass_d;
      boat_q  <= boat_d;
      busy_q  <= busy_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cat       = slot_pattern(cat_q);
  assign dog       = slot_pattern(dog_q);
  assign mouse     = slot_pattern(mouse_q);
  assign boat_side = boat_q;
  assign busy      = busy_q;
  assign win       = win_q;
  assign lose      = lose_q;
  assign err       = err_q;
  assign move_cnt  = cnt_q;

endmodule

// File: tb/tb_crossing_ctrl.sv
// Scoreboard bench for crossing_ctrl: a puzzle-level model predicts every
// animation step, crossing completion and rejected request.
module tb_crossing_ctrl;

  localparam int TD = 4;
  localparam int S  = 4;
  localparam int DoneCyc = (S - 1) * TD + 1;

  localparam int EvStep = 0;
  localparam int EvDone = 1;
  localparam int EvErr  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       go = 1'b0;
  logic [1:0] sel = 2'd0;
  logic [7:0] cat, dog, mouse, move_cnt;
  logic       boat_side, busy, win, lose, err;

  always #5 clk = ~clk;

  crossing_ctrl #(
    .TICK_DIV(TD),
    .SLOTS   (S)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .go       (go),
    .sel      (sel),
    .cat      (cat),
    .dog      (dog),
    .mouse    (mouse),
    .boat_side(boat_side),
    .busy     (busy),
    .win      (win),
    .lose     (lose),
    .err      (err),
    .move_cnt (move_cnt)
  );

  typedef struct {
    int         kind;
    logic [7:0] c, d, m;
    logic       boat, w, l;
    logic [7:0] cnt;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  // Puzzle model: slot of cat/dog/mouse, boat bank, crossings, outcome
  int   m_pos[3];
  int   m_boat, m_cnt;
  bit   m_win, m_lose;

  function automatic logic [7:0] pat(input int p);
    logic [7:0] base;
    base = 8'h03;
    return base << (2 * p);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_pos[i] = 0;
    m_boat = 0;
    m_cnt  = 0;
    m_win  = 1'b0;
    m_lose = 1'b0;
  endtask

  task automatic push_ev(input int kind, input int cyc);
    exp_t e;
    e.kind = kind;
    e.c    = pat(m_pos[0]);
    e.d    = pat(m_pos[1]);
    e.m    = pat(m_pos[2]);
    e.boat = (m_boat != 0);
    e.w    = m_win;
    e.l    = m_lose;
    e.cnt  = 8'(m_cnt);
    e.cyc  = cyc;
    sb_q.push_back(e);
  endtask

  // r: 0 legal crossing, 1 rejected, 2 restart from a finished game
  task automatic model_request(input int s, output int r);
    int bank, dir, away;
    if (m_win || m_lose) begin
      model_reset();
      r = 2;
    end else begin
      bank = (m_boat != 0) ? S - 1 : 0;
      if (s != 0 && m_pos[s-1] != bank) begin
        push_ev(EvErr, 0);
        r = 1;
      end else begin
        dir = (m_boat != 0) ? -1 : 1;
        if (s != 0) begin
          for (int k = 1; k < S; k++) begin
            m_pos[s-1] += dir;
            push_ev(EvStep, k * TD + 1);
          end
        end
        m_boat = 1 - m_boat;
        if (m_cnt < 255) m_cnt++;
        away = (m_boat != 0) ? 0 : S - 1;
        if (m_pos[0] == S - 1 && m_pos[1] == S - 1 && m_pos[2] == S - 1) m_win = 1'b1;
        else if (m_pos[0] == away && m_pos[2] == away) m_lose = 1'b1;
        else if (m_pos[1] == away && m_pos[0] == away) m_lose = 1'b1;
        push_ev(EvDone, DoneCyc);
        r = 0;
      end
    end
  endtask

  // Monitor: pops an expectation whenever the DUT shows a step, a finished
  // crossing or an error pulse
  logic [7:0] prev_c, prev_d, prev_m;
  logic       prev_busy;
  int         bcnt = 0;

  task automatic compare(input int kind, input int cyc);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event: kind %0d seen, nothing expected at %0t", kind, $time);
    end else begin
      e = sb_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("cat", cat, e.c);
      chk("dog", dog, e.d);
      chk("mouse", mouse, e.m);
      chk("boat_side", boat_side, e.boat);
      chk("win", win, e.w);
      chk("lose", lose, e.l);
      chk("move_cnt", move_cnt, e.cnt);
      if (kind == EvErr) chk("busy_on_err", busy, 1'b0);
      else chk("busy_cycles", cyc, e.cyc);
    end
  endtask

  // Sample outputs on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (!rst_n) begin
      bcnt = 0;
    end else begin
      if (busy) bcnt++;
      if (err) compare(EvErr, bcnt);
      if (busy && {cat, dog, mouse} != {prev_c, prev_d, prev_m}) compare(EvStep, bcnt);
      if (!busy && prev_busy) begin
        compare(EvDone, bcnt);
        bcnt = 0;
      end
    end
    prev_c    = cat;
    prev_d    = dog;
    prev_m    = mouse;
    prev_busy = busy;
  end

  task automatic do_reset();
    rst_n = 1'b0;
    go    = 1'b0;
    sel   = 2'd0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    model_reset();
  endtask

  task automatic check_initial(input string tag);
    chk({tag, "_cat"}, cat, 8'h03);
    chk({tag, "_dog"}, dog, 8'h03);
    chk({tag, "_mouse"}, mouse, 8'h03);
    chk({tag, "_boat"}, boat_side, 1'b0);
    chk({tag, "_cnt"}, move_cnt, 8'd0);
    chk({tag, "_win"}, win, 1'b0);
    chk({tag, "_lose"}, lose, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  // One request; optionally pulse go again while the crossing animates
  task automatic issue(input int s, input bit inj);
    int r, n, inj_at;
    model_request(s, r);
    go  = 1'b1;
    sel = s[1:0];
    @(negedge clk);
    go = 1'b0;
    if (r == 2) begin
      check_initial("restart");
    end else if (r == 1) begin
      @(negedge clk);
      chk("busy_after_err", busy, 1'b0);
    end else begin
      inj_at = $urandom_range(1, 8);
      n = 0;
      while (busy && n < 400) begin
        go = inj && (n == inj_at);
        if (go) sel = 2'($urandom_range(0, 3));
        @(negedge clk);
        n++;
      end
      go = 1'b0;
      chk("crossing_done_in_time", (n < 400), 1'b1);
    end
  endtask

  initial begin
    int r;
    do_reset();
    check_initial("reset");

    // Cat across, then a rejected mouse request from the wrong bank
    issue(1, 1'b0);
    issue(3, 1'b0);
    // Rest of the solution, with stray go pulses during some crossings
    issue(0, 1'b1);
    issue(2, 1'b0);
    issue(1, 1'b1);
    issue(3, 1'b0);
    issue(0, 1'b1);
    issue(1, 1'b0);
    chk("solved_win", win, 1'b1);
    issue(2, 1'b0);

    // Dog first leaves cat with mouse
    issue(2, 1'b0);
    chk("dog_first_lose", lose, 1'b1);
    issue(1, 1'b0);

    // Reset in the middle of a dog crossing, after step 2
    model_request(2, r);
    go  = 1'b1;
    sel = 2'd2;
    @(negedge clk);
    go = 1'b0;
    repeat (8) @(negedge clk);
    chk("dog_at_step2", dog, 8'h30);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_cat", cat, 8'h03);
    chk("midreset_dog", dog, 8'h03);
    chk("midreset_mouse", mouse, 8'h03);
    chk("midreset_boat", boat_side, 1'b0);
    chk("midreset_busy", busy, 1'b0);
    sb_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    // Mouse first leaves dog with cat
    issue(3, 1'b0);
    issue(0, 1'b0);

    // Random games
    repeat (60) issue($urandom_range(0, 3), ($urandom_range(0, 2) == 0));

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/crossing_ctrl.md
Name: crossing_ctrl

Overview:
- Game sequencer for the cat/dog/mouse river-crossing puzzle shown on the bicolor dot matrix.
- Accepts a crossing request: which animal rides with the farmer, or none.
- Animates the crossing as 2-bit-wide column blobs, then applies the eating rules.
- Flags win, lose or an illegal request.
- Its cat/dog/mouse outputs feed the row-scan dot-matrix driver directly.

Parameters:
- TICK_DIV, 1000, clk cycles per animation step (one slot of movement); must be >= 2.
- SLOTS, 4, column slots per row (2 LEDs each); slot 0 = left bank, slot SLOTS-1 = right bank.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- go  in  1  one-cycle request pulse
- sel  in  2  passenger, sampled with go: 0 none, 1 cat, 2 dog, 3 mouse
- cat  out  8  cat column pattern
- dog  out  8  dog column pattern
- mouse  out  8  mouse column pattern
- boat_side  out  1  farmer/boat bank: 0 left, 1 right
- busy  out  1  high while a crossing is animating
- win  out  1  level, puzzle solved
- lose  out  1  level, rule violated
- err  out  1  one-cycle pulse, illegal request rejected
- move_cnt  out  8  completed crossings, saturates at 255

Behaviour:
- Pattern encoding: each animal has a slot p (0..SLOTS-1); its pattern is 8'b00000011 << (2*p).
- Reset (async, rst_n low):
  - all animals at slot 0, so cat = dog = mouse = 8'b00000011;
  - boat_side = 0; busy, win, lose, err = 0; move_cnt = 0;
  - tick counter = 0; state IDLE;
  - a reset in any state, including mid-MOVE, takes effect immediately.
- FSM states: IDLE, MOVE, CHECK, WIN, LOSE.
- IDLE, on go:
  - sel = 0 (farmer alone) is always legal.
  - sel != 0 is legal only if the selected animal sits at the farmer's bank: slot 0 if boat_side = 0, slot SLOTS-1 if boat_side = 1.
  - Legal: latch the passenger, clear the tick counter, go to MOVE; busy is high from the next cycle.
  - Illegal: err pulses for exactly one cycle, the FSM stays in IDLE, and nothing else changes.
- MOVE:
  - The tick counter counts 0..TICK_DIV-1. On reaching TICK_DIV-1 it generates a step and wraps to 0.
  - Each step moves the passenger one slot toward the far bank: +1 if boat_side = 0, -1 if boat_side = 1.
  - After SLOTS-1 steps go to CHECK. With no passenger, the same number of steps elapses with no pattern change.
  - go is ignored in MOVE; no queueing.
- CHECK (exactly 1 cycle):
  - toggle boat_side;
  - increment move_cnt (saturating);
  - busy drops when leaving CHECK.
- Evaluation in CHECK, using the new boat_side; "unattended" = on the bank opposite the farmer:
  - if all three animals are at slot SLOTS-1, go to WIN;
  - else if cat and mouse are both unattended, go to LOSE;
  - else if dog and cat are both unattended, go to LOSE;
  - else go to IDLE.
- WIN / LOSE:
  - the win / lose output is held high and patterns are frozen;
  - go (any sel) returns to the reset state (positions, boat_side, move_cnt cleared) and IDLE on the next cycle; no err pulse.
- Latency: go accepted at cycle t; MOVE from t+1; step k occurs at t+k*TICK_DIV; CHECK at t+(SLOTS-1)*TICK_DIV+1; outputs are settled 1 cycle later.
- All outputs are registered; no combinational path from go/sel to any output.

Test Plan (TICK_DIV=4, SLOTS=4):
- Reset release -> cat = dog = mouse = 8'h03, boat_side = 0, move_cnt = 0, win = lose = err = busy = 0.
- go, sel = 1 -> cat goes 8'h0C, 8'h30, 8'hC0 at 4-cycle intervals; busy high 13 cycles; then boat_side = 1, move_cnt = 1, lose = 0.
- From reset, go, sel = 2 (dog) -> dog reaches 8'hC0, lose = 1 (cat and mouse unattended on the left); a further go returns all patterns to 8'h03 and move_cnt to 0.
- Full solution, sel sequence 1, 0, 2, 1, 3, 0, 1 -> lose stays 0 throughout; after the 7th crossing all patterns = 8'hC0, win = 1, move_cnt = 7, boat_side = 1.
- Illegal requests:
  - after the cat crossing, go, sel = 3 (mouse still on the left, boat on the right) -> err high 1 cycle, busy stays 0, no pattern change, move_cnt stays 1;
  - go pulsed mid-MOVE -> ignored.
- rst_n asserted at step 2 of a dog crossing -> all patterns 8'h03, boat_side = 0, busy = 0 in the same cycle; a new go after release works normally.
